// File: rtl/mnd_pkg.sv
// Shared definitions for the multiply/divide sequencer: MnDOp encodings,
// FSM state type and default cycle counts.
package mnd_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mndState_t;

endpackage

// File: rtl/mnd_if.sv
// EX-stage MnD control/operand bundle plus the sequencer's busy/stall/HI/LO
// results; master is the pipeline side, slave is the sequencer.
interface mnd_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic             we;
  logic             hilo_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             id_mnd_use;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, we, hilo_sel, a, b, flush, id_mnd_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, we, hilo_sel, a, b, flush, id_mnd_use,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/mnd_arith.sv
// Combinational multiply/divide core on the latched operands. Division works
// on magnitudes so truncation toward zero and the overflow case fall out naturally.
module mnd_arith
  import mnd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  input  logic [1:0]         op,
  output logic [2*WIDTH-1:0] result,
  output logic               divZero
);

  logic               isSigned;
  logic               negA;
  logic               negB;
  logic [2*WIDTH-1:0] extA;
  logic [2*WIDTH-1:0] extB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign isSigned = op[0];
  assign negA     = isSigned & opA[WIDTH-1];
  assign negB     = isSigned & opB[WIDTH-1];
  assign extA     = {{WIDTH{negA}}, opA};
  assign extB     = {{WIDTH{negB}}, opB};
  assign magA     = negA ? (~opA + 1'b1) : opA;
  assign magB     = negB ? (~opB + 1'b1) : opB;
  assign divZero  = (opB == '0);
  // Substitute divisor keeps the divider defined; the result is discarded anyway.
  assign divisor  = divZero ? {{(WIDTH-1){1'b0}}, 1'b1} : magB;
  assign quo      = magA / divisor;
  assign rem      = magA % divisor;

  always_comb begin
    result = '0;
    if (op[1]) begin
      result[2*WIDTH-1:WIDTH] = negA ? (~rem + 1'b1) : rem;
      result[WIDTH-1:0]       = (negA ^ negB) ? (~quo + 1'b1) : quo;
    end else begin
      result = extA * extB;
    end
  end

endmodule

// File: rtl/mnd_sequencer.sv
// Multiply/divide sequencer: fixed-latency FSM, HI/LO registers, mthi/mtlo
// writes and the ID-stage stall for MnD instructions behind an in-flight op.
module mnd_sequencer
  import mnd_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic      clk,
  input  logic      rst_n,
  mnd_if.slave      bus,
  output mndState_t stateDbg
);

  // Handshake: start is taken only in IDLE when not flushed; busy then stays
  // high for exactly N cycles. New MnD work in ID is held off by stall, so
  // start/we arriving while busy are simply ignored.
  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mndState_t          state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [WIDTH-1:0]   aLat, bLat;
  logic [1:0]         opLat;
  logic [WIDTH-1:0]   hiReg, loReg, hiNext, loNext;
  logic               latchEn;
  logic               accept;
  logic               busyInt;
  logic [2*WIDTH-1:0] arithResult;
  logic               divZero;

  mnd_arith #(.WIDTH(WIDTH)) u_arith (
    .opA     (aLat),
    .opB     (bLat),
    .op      (opLat),
    .result  (arithResult),
    .divZero (divZero)
  );

  assign accept = bus.start & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    hiNext    = hiReg;
    loNext    = loReg;
    latchEn   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          latchEn   = 1'b1;
          cntNext   = bus.op[1] ? DIV_LOAD : MULT_LOAD;
          stateNext = ST_RUN;
        end else if (bus.we && !bus.flush) begin
          if (bus.hilo_sel) hiNext = bus.a;
          else              loNext = bus.a;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          stateNext = ST_IDLE;
          cntNext   = '0;
        end else if (cnt == '0) begin
          stateNext = ST_IDLE;
          // A divide by zero burns its cycles but leaves HI/LO alone.
          if (!(opLat[1] && divZero)) begin
            hiNext = arithResult[2*WIDTH-1:WIDTH];
            loNext = arithResult[WIDTH-1:0];
          end
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      aLat  <= '0;
      bLat  <= '0;
      opLat <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else begin
      cnt   <= cntNext;
      hiReg <= hiNext;
      loReg <= loNext;
      if (latchEn) begin
        aLat  <= bus.a;
        bLat  <= bus.b;
        opLat <= bus.op;
      end
    end
  end

  assign busyInt   = (state == ST_RUN);
  assign bus.busy  = busyInt;
  assign bus.stall = bus.id_mnd_use & (busyInt | accept);
  assign bus.hi    = hiReg;
  assign bus.lo    = loReg;
  assign stateDbg  = state;

endmodule

// File: tb/tb_mnd_sequencer.sv
// Bench for mnd_sequencer: directed cases plus randomized ops, checked against
// an arithmetic reference model through an expected-value queue.
module tb_mnd_sequencer;
  import mnd_pkg::*;

  localparam int W     = 32;
  localparam int MULTN = 5;
  localparam int DIVN  = 10;

  logic      clk;
  logic      rst_n;
  mndState_t stateDbg;
  int        testsRun  = 0;
  int        failCount = 0;
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;
  logic [2*W-1:0] exp_q[$];

  mnd_if #(.WIDTH(W)) bus ();

  mnd_sequencer #(.WIDTH(W), .MULT_CYCLES(MULTN), .DIV_CYCLES(DIVN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .stateDbg (stateDbg)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the op rules.
  function automatic logic [63:0] refOp(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] curHi,
                                        input logic [31:0] curLo);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OP_MULTU: return ua * ub;
      OP_MULT:  return 64'(sa * sb);
      OP_DIVU: begin
        if (b == 0) return {curHi, curLo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {curHi, curLo};
        sq = sa / sb;
        sr = sa % sb;
        return {32'(sr), 32'(sq)};
      end
    endcase
  endfunction

  // abortKind: 0 none, 1 flush, 2 reset; abortAt is the 1-based busy cycle.
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic idUse, input int abortKind, input int abortAt);
    int n;
    logic [63:0] expv;
    n = op[1] ? DIVN : MULTN;
    exp_q.push_back(refOp(op, a, b, modelHi, modelLo));
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.id_mnd_use = idUse;
    #1 check("stall_at_start", 64'(bus.stall), 64'(idUse));
    @(posedge clk);
    #1 bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("busy_run", 64'(bus.busy), 64'd1);
      check("stall_run", 64'(bus.stall), 64'(idUse));
      if (abortKind == 1 && k == abortAt) begin
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        expv = exp_q.pop_front();
        check("busy_after_flush", 64'(bus.busy), 64'd0);
        check("hilo_after_flush", {bus.hi, bus.lo}, {modelHi, modelLo});
        bus.id_mnd_use = 1'b0;
        return;
      end
      if (abortKind == 2 && k == abortAt) begin
        rst_n = 1'b0;
        #1;
        expv = exp_q.pop_front();
        modelHi = '0;
        modelLo = '0;
        check("busy_after_reset", 64'(bus.busy), 64'd0);
        check("hilo_after_reset", {bus.hi, bus.lo}, 64'd0);
        check("state_after_reset", 64'(stateDbg), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        bus.id_mnd_use = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check("busy_done", 64'(bus.busy), 64'd0);
    check("stall_done", 64'(bus.stall), 64'd0);
    expv = exp_q.pop_front();
    check($sformatf("hilo_op%0d", op), {bus.hi, bus.lo}, expv);
    modelHi = expv[63:32];
    modelLo = expv[31:0];
    bus.id_mnd_use = 1'b0;
  endtask

  task automatic doWrite(input logic sel, input logic [31:0] val, input logic fl);
    @(negedge clk);
    bus.we = 1'b1; bus.hilo_sel = sel; bus.a = val; bus.flush = fl;
    @(posedge clk);
    #1 bus.we = 1'b0; bus.flush = 1'b0;
    if (!fl) begin
      if (sel) modelHi = val;
      else     modelLo = val;
    end
    @(negedge clk);
    check("hilo_after_write", {bus.hi, bus.lo}, {modelHi, modelLo});
    check("busy_after_write", 64'(bus.busy), 64'd0);
  endtask

  task automatic startWithFlush(input logic [1:0] op);
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = op; bus.a = $urandom; bus.b = $urandom;
    bus.id_mnd_use = 1'b1;
    #1 check("stall_start_flushed", 64'(bus.stall), 64'd0);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0; bus.id_mnd_use = 1'b0;
    @(negedge clk);
    check("busy_start_flushed", 64'(bus.busy), 64'd0);
    check("hilo_start_flushed", {bus.hi, bus.lo}, {modelHi, modelLo});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.we = 1'b0; bus.hilo_sel = 1'b0;
    bus.a = '0; bus.b = '0; bus.flush = 1'b0; bus.id_mnd_use = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_state", 64'(stateDbg), 64'(ST_IDLE));
    rst_n = 1'b1;

    // Directed cases
    runOp(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0);
    check("mult_neg3x5", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    runOp(OP_DIVU, 32'd100, 32'd7, 1'b0, 0, 0);
    check("divu_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});
    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
    check("div_neg7_2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0);
    doWrite(1'b1, 32'h1234_5678, 1'b0);
    check("mthi_value", 64'(bus.hi), 64'h1234_5678);
    doWrite(1'b0, 32'hDEAD_BEEF, 1'b1);
    runOp(OP_DIV, 32'd1000, 32'd3, 1'b1, 1, 3);
    runOp(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 2, 2);
    doWrite(1'b1, 32'hA, 1'b0);
    doWrite(1'b0, 32'hB, 1'b0);
    runOp(OP_DIV, 32'd55, 32'd0, 1'b0, 0, 0);
    check("divzero_keep", {bus.hi, bus.lo}, {32'hA, 32'hB});
    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0);
    check("div_overflow", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});
    startWithFlush(OP_MULT);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        doWrite(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
      end else if (sel == 2) begin
        startWithFlush(2'($urandom_range(0, 3)));
      end else begin
        rop = 2'($urandom_range(0, 3));
        ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        case ($urandom_range(0, 7))
          0:       rb = 32'd0;
          1:       rb = 32'hFFFF_FFFF;
          2:       rb = 32'($urandom_range(1, 9));
          default: rb = $urandom;
        endcase
        runOp(rop, ra, rb, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0) ? 1 : 0, $urandom_range(1, 5));
      end
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
